// File: rtl/servo_scan_sequencer.sv
// Servo/IR scan sequencer: steps the servo angle, settles, samples IR, and writes the sample to memory.
// Optional feature: define SCAN_BIDIR_EN for a ping-pong sweep (default build is unidirectional).
module servo_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 25_000_000,
    parameter logic [15:0] ANGLE_MIN     = 16'd0,
    parameter logic [15:0] ANGLE_MAX     = 16'd180,
    parameter logic [15:0] ANGLE_STEP    = 16'd15,
    parameter logic [23:0] BASE_ADDR     = 24'h000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] angle,
    output logic        ir_req,
    input  logic        ir_ack,
    input  logic [15:0] ir_data,
    output logic        mem_req,
    input  logic        mem_grant,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        scan_done
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_MOVE, ST_SETTLE, ST_SAMPLE, ST_WRITE, ST_NEXT
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      angle_reg, angle_next;
    logic [7:0]       slot_reg, slot_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ir_req_reg, ir_req_next;
    logic             mem_req_reg, mem_req_next;
    logic [23:0]      mem_addr_reg, mem_addr_next;
    logic [15:0]      mem_wdata_reg, mem_wdata_next;
    logic             busy_reg, busy_next;
    logic             scan_done_reg, scan_done_next;
    logic             step_up;

    // 17-bit sum so a step past 16'hFFFF still counts as beyond the top
    logic [16:0] up_sum;
    logic        at_top;
    assign up_sum = {1'b0, angle_reg} + {1'b0, ANGLE_STEP};
    assign at_top = up_sum > {1'b0, ANGLE_MAX};

`ifdef SCAN_BIDIR_EN
    logic dir_down_reg, dir_down_next;
    logic step_down;
    logic at_bottom;
    assign at_bottom = {1'b0, angle_reg} < ({1'b0, ANGLE_MIN} + {1'b0, ANGLE_STEP});
`else
    logic wrap;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            angle_reg     <= ANGLE_MIN;
            slot_reg      <= 8'd0;
            cnt_reg       <= '0;
            ir_req_reg    <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= 16'd0;
            busy_reg      <= 1'b0;
            scan_done_reg <= 1'b0;
`ifdef SCAN_BIDIR_EN
            dir_down_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            angle_reg     <= angle_next;
            slot_reg      <= slot_next;
            cnt_reg       <= cnt_next;
            ir_req_reg    <= ir_req_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= busy_next;
            scan_done_reg <= scan_done_next;
`ifdef SCAN_BIDIR_EN
            dir_down_reg  <= dir_down_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        angle_next     = angle_reg;
        slot_next      = slot_reg;
        cnt_next       = cnt_reg;
        ir_req_next    = ir_req_reg;
        mem_req_next   = mem_req_reg;
        mem_wdata_next = mem_wdata_reg;
        scan_done_next = 1'b0;
        step_up        = 1'b0;
`ifdef SCAN_BIDIR_EN
        dir_down_next  = dir_down_reg;
        step_down      = 1'b0;
`else
        wrap           = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                angle_next = ANGLE_MIN;
                slot_next  = 8'd0;
`ifdef SCAN_BIDIR_EN
                dir_down_next = 1'b0;
`endif
                if (enable) state_next = ST_MOVE;
            end
            ST_MOVE: begin
                cnt_next   = SETTLE_LOAD;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    ir_req_next = 1'b1;
                    state_next  = ST_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (ir_ack) begin
                    mem_wdata_next = ir_data;
                    ir_req_next    = 1'b0;
                    mem_req_next   = 1'b1;
                    state_next     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_grant) begin
                    mem_req_next = 1'b0;
                    state_next   = ST_NEXT;
                end
            end
            ST_NEXT: begin
`ifdef SCAN_BIDIR_EN
                // A sweep with a single reachable point simply stays put at each reversal
                if (!dir_down_reg) begin
                    if (at_top) begin
                        scan_done_next = 1'b1;
                        dir_down_next  = 1'b1;
                        step_down      = !at_bottom;
                    end else begin
                        step_up = 1'b1;
                    end
                end else begin
                    if (at_bottom) begin
                        scan_done_next = 1'b1;
                        dir_down_next  = 1'b0;
                        step_up        = !at_top;
                    end else begin
                        step_down = 1'b1;
                    end
                end
                if (step_down) begin
                    angle_next = angle_reg - ANGLE_STEP;
                    slot_next  = slot_reg - 8'd1;
                end
`else
                if (at_top) begin
                    scan_done_next = 1'b1;
                    wrap           = 1'b1;
                end else begin
                    step_up = 1'b1;
                end
                if (wrap) begin
                    angle_next = ANGLE_MIN;
                    slot_next  = 8'd0;
                end
`endif
                if (step_up) begin
                    angle_next = up_sum[15:0];
                    slot_next  = slot_reg + 8'd1;
                end
                if (enable) begin
                    state_next = ST_MOVE;
                end else begin
                    // Park the servo immediately rather than commanding the next point first
                    state_next = ST_IDLE;
                    angle_next = ANGLE_MIN;
                    slot_next  = 8'd0;
`ifdef SCAN_BIDIR_EN
                    dir_down_next = 1'b0;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next     = (state_next != ST_IDLE);
        mem_addr_next = BASE_ADDR + {16'd0, slot_next};
    end

    assign angle     = angle_reg;
    assign ir_req    = ir_req_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
    assign scan_done = scan_done_reg;
endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Bench for servo_scan_sequencer: directed sequence with randomized data/handshake delays,
// checked against a point-index model of the sweep (two instances: MAX=180 and MAX=170).
module tb_servo_scan_sequencer;
    localparam int          S     = 4;
    localparam int          AMIN  = 0;
    localparam int          AMAX  = 180;
    localparam int          AMAX2 = 170;
    localparam int          ASTEP = 45;
    localparam logic [23:0] BASE  = 24'h000100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, ir_ack, mem_grant;
    logic [15:0] ir_data;
    logic [15:0] angle, mem_wdata;
    logic [23:0] mem_addr;
    logic        ir_req, mem_req, mem_we, busy, scan_done;

    logic        en2, ack2, grant2;
    logic [15:0] data2;
    logic [15:0] angle2, mem_wdata2;
    logic [23:0] mem_addr2;
    logic        ir_req2, mem_req2, mem_we2, busy2, scan_done2;

    servo_scan_sequencer #(
        .SETTLE_CYCLES(S), .ANGLE_MIN(16'(AMIN)), .ANGLE_MAX(16'(AMAX)),
        .ANGLE_STEP(16'(ASTEP)), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .angle(angle),
        .ir_req(ir_req), .ir_ack(ir_ack), .ir_data(ir_data),
        .mem_req(mem_req), .mem_grant(mem_grant), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .scan_done(scan_done)
    );

    servo_scan_sequencer #(
        .SETTLE_CYCLES(S), .ANGLE_MIN(16'(AMIN)), .ANGLE_MAX(16'(AMAX2)),
        .ANGLE_STEP(16'(ASTEP)), .BASE_ADDR(BASE)
    ) dut2 (
        .clk(clk), .reset(reset), .enable(en2), .angle(angle2),
        .ir_req(ir_req2), .ir_ack(ack2), .ir_data(data2),
        .mem_req(mem_req2), .mem_grant(grant2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_we(mem_we2), .busy(busy2), .scan_done(scan_done2)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [15:0] log_angle[$];
    logic [23:0] log_addr[$];
    logic [15:0] log_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the p-th point since leaving IDLE visits sweep index k of n points
    function automatic int n_points(input int amax);
        return (amax - AMIN) / ASTEP + 1;
    endfunction

    function automatic int model_k(input int p, input int n);
        int period;
        int m;
`ifdef SCAN_BIDIR_EN
        if (n == 1) return 0;
        period = 2 * (n - 1);
        m = p % period;
        return (m <= n - 1) ? m : period - m;
`else
        period = n;
        m = p % period;
        return m;
`endif
    endfunction

    function automatic logic model_done(input int p, input int n);
        int k;
        k = model_k(p, n);
`ifdef SCAN_BIDIR_EN
        return (k == n - 1) || (k == 0 && p > 0);
`else
        return k == n - 1;
`endif
    endfunction

    // Always-ready responder for the second instance; logs every write it grants
    initial begin
        ack2 = 1'b0; grant2 = 1'b0; data2 = 16'd0;
        forever begin
            @(negedge clk);
            ack2   = (ir_req2 === 1'b1);
            data2  = 16'h0500 + 16'(log_angle.size());
            grant2 = (mem_req2 === 1'b1);
            if (grant2) begin
                log_angle.push_back(angle2);
                log_addr.push_back(mem_addr2);
                log_data.push_back(mem_wdata2);
            end
        end
    end

    task automatic wait_ir_req();
        int waited;
        waited = 0;
        while (ir_req !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("ir_req_seen", ir_req, 1'b1);
    endtask

    task automatic do_point(input int p, input logic [15:0] data, input int ackd,
                            input int grantd, input bit stall_checks);
        int n;
        int k;
        n = n_points(AMAX);
        k = model_k(p, n);
        wait_ir_req();
        chk("sample_angle", angle, 32'(AMIN + k * ASTEP));
        chk("sample_busy", busy, 1'b1);
        if (ackd >= 1) begin
            mem_grant = 1'b1;  // stray grant outside WRITE must be ignored
            @(negedge clk);
            mem_grant = 1'b0;
            repeat (ackd - 1) @(negedge clk);
            chk("ir_req_hold", ir_req, 1'b1);
            chk("no_early_write", mem_req, 1'b0);
        end
        ir_ack = 1'b1; ir_data = data;
        @(negedge clk);
        ir_ack = 1'b0; ir_data = 16'($urandom);
        chk("ir_req_drop", ir_req, 1'b0);
        chk("mem_req", mem_req, 1'b1);
        chk("mem_we", mem_we, 1'b1);
        chk("mem_addr", mem_addr, BASE + 24'(k));
        chk("mem_wdata", mem_wdata, data);
        for (int i = 0; i < grantd; i++) begin
            if (stall_checks) ir_ack = 1'b1;  // stray ack outside SAMPLE must be ignored
            @(negedge clk);
            ir_ack = 1'b0;
            if (stall_checks) begin
                chk("stall_req", mem_req, 1'b1);
                chk("stall_addr", mem_addr, BASE + 24'(k));
                chk("stall_wdata", mem_wdata, data);
                chk("stall_angle", angle, 32'(AMIN + k * ASTEP));
            end
        end
        mem_grant = 1'b1;
        @(negedge clk);
        mem_grant = 1'b0;
        chk("write_release", mem_req, 1'b0);
        chk("we_release", mem_we, 1'b0);
        @(negedge clk);
        chk("scan_done", scan_done, model_done(p, n));
    endtask

    initial begin
        int cyc;
        int n2;
        reset = 1'b1; enable = 1'b0; en2 = 1'b0;
        ir_ack = 1'b0; ir_data = 16'd0; mem_grant = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_angle", angle, 32'(AMIN));
        chk("rst_ir_req", ir_req, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_scan_done", scan_done, 1'b0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // First sweep: fixed data pattern, one-cycle handshakes; then randomized points
        enable = 1'b1; en2 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ir_req !== 1'b1 && cyc < 50);
        chk("ir_req_latency", cyc, S + 2);
        for (int p = 0; p < 5; p++) do_point(p, 16'h00A0 + 16'(p), 1, 1, 1'b0);
        for (int p = 5; p < 12; p++)
            do_point(p, 16'($urandom), $urandom_range(0, 3),
                     (p == 7) ? 10 : $urandom_range(0, 3), p == 7);

        // Second instance ran alongside with a non-aligned top bound
        en2 = 1'b0;
        n2 = n_points(AMAX2);
        chk("dut2_count", log_angle.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < log_angle.size(); i++) begin
            chk("dut2_angle", log_angle[i], 32'(AMIN + model_k(i, n2) * ASTEP));
            chk("dut2_addr", log_addr[i], BASE + 24'(model_k(i, n2)));
            chk("dut2_data", log_data[i], 16'h0500 + 16'(i));
        end

        // Drop enable mid-point: the point completes, then the block parks
        @(negedge clk);
        enable = 1'b0;
        do_point(12, 16'($urandom), 1, 2, 1'b0);
        chk("park_busy", busy, 1'b0);
        chk("park_angle", angle, 32'(AMIN));
        repeat (5) @(negedge clk);
        chk("park_ir_req", ir_req, 1'b0);
        chk("park_mem_addr", mem_addr, BASE);

        // Fresh scan, then reset during a write with grant offered on the same cycle
        enable = 1'b1;
        do_point(0, 16'($urandom), 0, 1, 1'b0);
        wait_ir_req();
        ir_ack = 1'b1; ir_data = 16'h5A5A;
        @(negedge clk);
        ir_ack = 1'b0;
        chk("pre_rst_req", mem_req, 1'b1);
        reset = 1'b1; mem_grant = 1'b1;
        @(negedge clk);
        chk("rst_wr_req", mem_req, 1'b0);
        chk("rst_wr_we", mem_we, 1'b0);
        chk("rst_wr_busy", busy, 1'b0);
        chk("rst_wr_angle", angle, 32'(AMIN));
        chk("rst_wr_addr", mem_addr, BASE);
        chk("rst_wr_done", scan_done, 1'b0);
        reset = 1'b0; mem_grant = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);
        chk("post_rst_ir_req", ir_req, 1'b0);
        enable = 1'b1;
        do_point(0, 16'($urandom), 1, 0, 1'b0);
        do_point(1, 16'($urandom), 2, 1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
